// File: rtl/pe_dot_sequencer_if.sv
// pe_dot_sequencer_if: descriptor, feature-bus, filter-read and pe_dot sideband signals of one dot sequencer
//   slave  : sequencer side (takes i_* and drives o_*)
//   master : feeder / bench side (drives i_* and takes o_*)
interface pe_dot_sequencer_if #(
   parameter int VEC_W  = 12,
   parameter int OUT_W  = 12,
   parameter int ADDR_W = 10
);
   logic              i_cfg_valid;
   logic              o_cfg_ready;
   logic [VEC_W-1:0]  i_cfg_num_vectors;
   logic [OUT_W-1:0]  i_cfg_num_outputs;
   logic [ADDR_W-1:0] i_cfg_filter_base;
   logic              i_feature_valid;
   logic              o_feature_ready;
   logic              o_filter_rd_en;
   logic [ADDR_W-1:0] o_filter_rd_addr;
   logic              o_dot_in_valid;
   logic              o_dot_out_valid;
   logic              o_acc_first;
   logic              o_acc_last;
   logic              o_busy;
   logic              o_done;
   modport slave (
      input  i_cfg_valid, i_cfg_num_vectors, i_cfg_num_outputs, i_cfg_filter_base, i_feature_valid,
      output o_cfg_ready, o_feature_ready, o_filter_rd_en, o_filter_rd_addr, o_dot_in_valid,
             o_dot_out_valid, o_acc_first, o_acc_last, o_busy, o_done
   );
   modport master (
      output i_cfg_valid, i_cfg_num_vectors, i_cfg_num_outputs, i_cfg_filter_base, i_feature_valid,
      input  o_cfg_ready, o_feature_ready, o_filter_rd_en, o_filter_rd_addr, o_dot_in_valid,
             o_dot_out_valid, o_acc_first, o_acc_last, o_busy, o_done
   );
endinterface

// File: rtl/pe_dot_sequencer.sv
// pe_dot_sequencer: paces one dot-product job's feature beats and filter reads, and delays valid/first/last sidebands to match pe_dot
//   clock  : single clock
//   resetn : asynchronous active-low reset
//   bus    : pe_dot_sequencer_if.slave (descriptor handshake, feature handshake, filter read, pe_dot sidebands, busy/done)
module pe_dot_sequencer #(
   parameter int DOT_LATENCY   = 5,
   parameter int FILTER_RD_LAT = 2,
   parameter int VEC_W         = 12,
   parameter int OUT_W         = 12,
   parameter int ADDR_W        = 10
) (
   input logic clock,
   input logic resetn,
   pe_dot_sequencer_if.slave bus
);
   localparam int PIPE_LAT = FILTER_RD_LAT + DOT_LATENCY;
   localparam int DRAIN_W  = $clog2(PIPE_LAT + 1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t            state;
   logic [VEC_W-1:0]  num_vectors, vec_cnt;
   logic [OUT_W-1:0]  num_outputs, out_cnt;
   logic [ADDR_W-1:0] filter_base;
   logic [DRAIN_W-1:0] drain_cnt;
   logic              empty_done;
   logic              cfg_accept, cfg_empty, accept, first, last, last_out, drain_end;
   // in_sr carries accepts to the pe_dot inputs; out_sr carries {valid, first, last} to its result
   logic              in_sr [FILTER_RD_LAT];
   logic [2:0]        out_sr [PIPE_LAT];
   assign cfg_accept = state == IDLE && bus.i_cfg_valid;
   assign cfg_empty  = bus.i_cfg_num_vectors == '0 || bus.i_cfg_num_outputs == '0;
   assign accept     = state == RUN && bus.i_feature_valid;
   assign first      = vec_cnt == '0;
   assign last       = vec_cnt == num_vectors - VEC_W'(1);
   assign last_out   = out_cnt == num_outputs - OUT_W'(1);
   // DRAIN begins the cycle after the last accept, so its final cycle lines up with the last result
   assign drain_end  = state == DRAIN && drain_cnt == DRAIN_W'(PIPE_LAT - 1);
   assign bus.o_cfg_ready      = state == IDLE;
   assign bus.o_feature_ready  = state == RUN;
   assign bus.o_filter_rd_en   = accept;
   assign bus.o_filter_rd_addr = accept ? filter_base + ADDR_W'(vec_cnt) : '0;
   assign bus.o_dot_in_valid   = in_sr[FILTER_RD_LAT-1];
   assign bus.o_dot_out_valid  = out_sr[PIPE_LAT-1][2];
   assign bus.o_acc_first      = out_sr[PIPE_LAT-1][1];
   assign bus.o_acc_last       = out_sr[PIPE_LAT-1][0];
   assign bus.o_busy           = state != IDLE;
   assign bus.o_done           = empty_done || drain_end;
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         num_vectors <= '0;
         num_outputs <= '0;
         filter_base <= '0;
         vec_cnt     <= '0;
         out_cnt     <= '0;
         drain_cnt   <= '0;
         empty_done  <= 1'b0;
      end else begin
         // an empty job completes straight from IDLE with a done pulse one cycle later
         empty_done <= cfg_accept && cfg_empty;
         case (state)
            IDLE: if (bus.i_cfg_valid) begin
               num_vectors <= bus.i_cfg_num_vectors;
               num_outputs <= bus.i_cfg_num_outputs;
               filter_base <= bus.i_cfg_filter_base;
               vec_cnt     <= '0;
               out_cnt     <= '0;
               if (!cfg_empty) state <= RUN;
            end
            RUN: if (accept) begin
               if (last) begin
                  vec_cnt <= '0;
                  if (last_out) begin
                     state     <= DRAIN;
                     drain_cnt <= '0;
                  end else out_cnt <= out_cnt + OUT_W'(1);
               end else vec_cnt <= vec_cnt + VEC_W'(1);
            end
            DRAIN: if (drain_end) state <= IDLE;
                   else drain_cnt <= drain_cnt + DRAIN_W'(1);
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < FILTER_RD_LAT; i++) in_sr[i] <= 1'b0;
         for (int i = 0; i < PIPE_LAT; i++) out_sr[i] <= 3'b000;
      end else begin
         in_sr[0]  <= accept;
         out_sr[0] <= {accept, accept && first, accept && last};
         for (int i = 1; i < FILTER_RD_LAT; i++) in_sr[i] <= in_sr[i-1];
         for (int i = 1; i < PIPE_LAT; i++) out_sr[i] <= out_sr[i-1];
      end
   end
endmodule

// File: tb/tb_pe_dot_sequencer.sv
// tb_pe_dot_sequencer: table-driven and directed checks of pe_dot_sequencer
module tb_pe_dot_sequencer;
   logic clock = 1'b0;
   logic resetn = 1'b0;
   int checks = 0;
   int errors = 0;
   pe_dot_sequencer_if #(.VEC_W(12), .OUT_W(12), .ADDR_W(10)) bus ();
   pe_dot_sequencer dut (.clock(clock), .resetn(resetn), .bus(bus));
   always #5 clock = ~clock;
   typedef struct packed {
      logic cv, fv, ready, fready, rd;
      logic [9:0] addr;
      logic inv, outv, first, last, done, busy;
   } row_t;
   row_t tbl[$];
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask
   function automatic logic [18:0] obs();
      return {bus.o_cfg_ready, bus.o_feature_ready, bus.o_filter_rd_en, bus.o_filter_rd_addr,
              bus.o_dot_in_valid, bus.o_dot_out_valid, bus.o_acc_first, bus.o_acc_last,
              bus.o_done, bus.o_busy};
   endfunction
   function automatic void r(input int cv, fv, ready, fready, rd, addr, inv, outv, first, last, done, busy);
      tbl.push_back({1'(cv), 1'(fv), 1'(ready), 1'(fready), 1'(rd), 10'(addr),
                     1'(inv), 1'(outv), 1'(first), 1'(last), 1'(done), 1'(busy)});
   endfunction
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic cfg(input int vec, input int outs, input int base);
      bus.i_cfg_num_vectors = 12'(vec);
      bus.i_cfg_num_outputs = 12'(outs);
      bus.i_cfg_filter_base = 10'(base);
   endtask
   task automatic run_table(input string name);
      foreach (tbl[i]) begin
         bus.i_cfg_valid     = tbl[i].cv;
         bus.i_feature_valid = tbl[i].fv;
         @(negedge clock);
         chk($sformatf("%s cycle %0d", name, i), int'(obs()), int'(tbl[i][18:0]));
         tick();
      end
      tbl.delete();
   endtask
   task automatic wait_done(input string name);
      bit seen = 0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clock);
         seen = bus.o_done;
         tick();
      end
      chk({name, " done within bound"}, int'(seen), 1);
   endtask
   initial begin
      int n_out, n_fl, n_done, done_outv, n_rd, bad_addr, bad;
      bit seen;
      bus.i_cfg_valid = 0;
      bus.i_feature_valid = 0;
      cfg(0, 0, 0);
      @(negedge clock);
      chk("reset state", int'(obs()), int'(19'h40000));
      tick();
      tick();
      resetn = 1'b1;
      @(negedge clock);
      chk("idle after reset", int'(obs()), int'(19'h40000));
      tick();
      // T1: vec=3 out=2 base=3FE, feature_valid held
      cfg(3, 2, 'h3FE);
      r(1,1,1,0,0,'h000,0,0,0,0,0,0);
      r(0,1,0,1,1,'h3FE,0,0,0,0,0,1);
      r(0,1,0,1,1,'h3FF,0,0,0,0,0,1);
      r(0,1,0,1,1,'h000,1,0,0,0,0,1);
      r(0,1,0,1,1,'h3FE,1,0,0,0,0,1);
      r(0,1,0,1,1,'h3FF,1,0,0,0,0,1);
      r(0,1,0,1,1,'h000,1,0,0,0,0,1);
      r(0,1,0,0,0,'h000,1,0,0,0,0,1);
      r(0,1,0,0,0,'h000,1,1,1,0,0,1);
      r(0,1,0,0,0,'h000,0,1,0,0,0,1);
      r(0,1,0,0,0,'h000,0,1,0,1,0,1);
      r(0,1,0,0,0,'h000,0,1,1,0,0,1);
      r(0,1,0,0,0,'h000,0,1,0,0,0,1);
      r(0,1,0,0,0,'h000,0,1,0,1,1,1);
      r(0,0,1,0,0,'h000,0,0,0,0,0,0);
      run_table("T1");
      // T2: vec=4 out=1 base=010, feature_valid toggling
      cfg(4, 1, 'h010);
      r(1,0,1,0,0,'h000,0,0,0,0,0,0);
      r(0,1,0,1,1,'h010,0,0,0,0,0,1);
      r(0,0,0,1,0,'h000,0,0,0,0,0,1);
      r(0,1,0,1,1,'h011,1,0,0,0,0,1);
      r(0,0,0,1,0,'h000,0,0,0,0,0,1);
      r(0,1,0,1,1,'h012,1,0,0,0,0,1);
      r(0,0,0,1,0,'h000,0,0,0,0,0,1);
      r(0,1,0,1,1,'h013,1,0,0,0,0,1);
      r(0,0,0,0,0,'h000,0,1,1,0,0,1);
      r(0,0,0,0,0,'h000,1,0,0,0,0,1);
      r(0,0,0,0,0,'h000,0,1,0,0,0,1);
      r(0,0,0,0,0,'h000,0,0,0,0,0,1);
      r(0,0,0,0,0,'h000,0,1,0,0,0,1);
      r(0,0,0,0,0,'h000,0,0,0,0,0,1);
      r(0,0,0,0,0,'h000,0,1,0,1,1,1);
      r(0,0,1,0,0,'h000,0,0,0,0,0,0);
      run_table("T2");
      // T3: empty jobs complete from IDLE
      for (int j = 0; j < 2; j++) begin
         cfg(j == 0 ? 0 : 2, j == 0 ? 4 : 0, 5);
         bus.i_cfg_valid = 1;
         bus.i_feature_valid = 1;
         @(negedge clock);
         chk($sformatf("T3.%0d accept cycle", j), int'(obs()), int'(19'h40000));
         tick();
         bus.i_cfg_valid = 0;
         @(negedge clock);
         chk($sformatf("T3.%0d done pulse", j), int'(obs()), int'(19'h40002));
         tick();
         bad = 0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            bad += int'(obs() != 19'h40000);
            tick();
         end
         chk($sformatf("T3.%0d quiet after done", j), bad, 0);
      end
      // T4: vec=1 out=5, every result is first and last
      cfg(1, 5, 'h100);
      bus.i_cfg_valid = 1;
      bus.i_feature_valid = 1;
      tick();
      bus.i_cfg_valid = 0;
      n_out = 0; n_fl = 0; n_done = 0; done_outv = 0; n_rd = 0; bad_addr = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clock);
         n_out += int'(bus.o_dot_out_valid);
         n_fl += int'(bus.o_dot_out_valid && bus.o_acc_first && bus.o_acc_last);
         n_done += int'(bus.o_done);
         done_outv += int'(bus.o_done && bus.o_dot_out_valid);
         n_rd += int'(bus.o_filter_rd_en);
         bad_addr += int'(bus.o_filter_rd_en && bus.o_filter_rd_addr != 10'h100);
         tick();
      end
      chk("T4 out_valid beats", n_out, 5);
      chk("T4 first&last beats", n_fl, 5);
      chk("T4 done pulses", n_done, 1);
      chk("T4 done with last out_valid", done_outv, 1);
      chk("T4 read strobes", n_rd, 5);
      chk("T4 bad addresses", bad_addr, 0);
      // T5: reset after two of eight beats
      cfg(4, 2, 0);
      bus.i_cfg_valid = 1;
      bus.i_feature_valid = 1;
      tick();
      bus.i_cfg_valid = 0;
      tick();
      tick();
      resetn = 1'b0;
      #1;
      chk("T5 outputs cleared at reset", int'(obs() & 19'h3FFFF), 0);
      @(negedge clock);
      chk("T5 outputs held in reset", int'(obs() & 19'h3FFFF), 0);
      tick();
      resetn = 1'b1;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         bad += int'(obs() != 19'h40000);
         tick();
      end
      chk("T5 idle after aborted job", bad, 0);
      // T6: descriptor held valid across a job
      cfg(2, 1, 'h020);
      bus.i_cfg_valid = 1;
      bus.i_feature_valid = 1;
      tick();
      bad = 0;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clock);
         bad += int'(bus.o_cfg_ready);
         seen = bus.o_done;
         tick();
      end
      chk("T6 done seen", int'(seen), 1);
      chk("T6 ready during job", bad, 0);
      @(negedge clock);
      chk("T6 ready after done", int'({bus.o_cfg_ready, bus.o_busy}), 2);
      tick();
      @(negedge clock);
      chk("T6 busy after re-accept", int'({bus.o_cfg_ready, bus.o_busy}), 1);
      bus.i_cfg_valid = 0;
      tick();
      wait_done("T6 second job");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
